// File: rtl/rr_interval_unit.sv
// R-R interval extractor: validates successive R-peak addresses, keeps an 8-beat mean and
// presents each accepted interval through a valid/ready record. Optional macro: RR_IRREGULAR_EN.
module rr_interval_unit #(
    parameter int RR_MIN = 72,
    parameter int RR_W   = 32
) (
    input  logic            clock_iht,
    input  logic            reset_n,
    input  logic [RR_W-1:0] addr_R_peak,
    output logic [RR_W-1:0] rr_interval,
    output logic [RR_W-1:0] rr_avg,
    output logic            rr_valid,
    input  logic            rr_ready,
    output logic [15:0]     beat_count,
    output logic            rr_irregular,
    output logic            overflow
);

    typedef enum logic [1:0] {IDLE, REF, ARMED} state_t;

    state_t          state_q, state_d;
    logic [RR_W-1:0] addr_q;
    logic [RR_W-1:0] last_peak;
    logic [RR_W-1:0] slots [8];
    logic [2:0]      ptr;
    logic [RR_W+2:0] sum, sum_next;
    logic            evt, accept, irr_d;
    logic [RR_W-1:0] rr;

    logic            vld_p0;
    logic [RR_W-1:0] rr_p0;
    logic [RR_W-1:0] avg_p0;
    logic            irr_p0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

`ifdef RR_IRREGULAR_EN
    function automatic logic deviates(input logic [RR_W-1:0] x, input logic [RR_W-1:0] avg);
        logic [RR_W-1:0] d;
        d = (x > avg) ? x - avg : avg - x;
        return d > (avg >> 2);
    endfunction

    assign irr_d = (state_q == ARMED) && deviates(rr, sum[RR_W+2:3]);
`else
    assign irr_d = 1'b0;
`endif

    // Modular subtraction gives the forward distance across address wrap-around.
    assign rr  = addr_R_peak - last_peak;
    assign evt = (addr_R_peak != addr_q);

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        sum_next = sum;
        case (state_q)
            IDLE: begin
                if (evt) state_d = REF;
            end
            REF: begin
                if (evt && (rr >= RR_W'(RR_MIN))) begin
                    accept   = 1'b1;
                    state_d  = ARMED;
                    sum_next = {rr, 3'b000};
                end
            end
            ARMED: begin
                if (evt && (rr >= RR_W'(RR_MIN))) begin
                    accept   = 1'b1;
                    sum_next = sum - {3'b000, slots[ptr]} + {3'b000, rr};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_iht) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Stage p0: event qualification, last-peak and averager update
    always_ff @(posedge clock_iht) begin
        if (!reset_n) begin
            addr_q    <= '0;
            last_peak <= '0;
            sum       <= '0;
            ptr       <= '0;
            for (int i = 0; i < 8; i++) slots[i] <= '0;
            vld_p0    <= 1'b0;
            rr_p0     <= '0;
            avg_p0    <= '0;
            irr_p0    <= 1'b0;
        end else begin
            addr_q <= addr_R_peak;
            vld_p0 <= accept;
            if (state_q == IDLE && evt) last_peak <= addr_R_peak;
            if (accept) begin
                last_peak <= addr_R_peak;
                sum       <= sum_next;
                rr_p0     <= rr;
                avg_p0    <= sum_next[RR_W+2:3];
                irr_p0    <= irr_d;
                if (state_q == REF) begin
                    for (int i = 0; i < 8; i++) slots[i] <= rr;
                    ptr <= '0;
                end else begin
                    slots[ptr] <= rr;
                    ptr        <= ptr + 3'd1;
                end
            end
        end
    end

    // Stage p1: output record and handshake
    always_ff @(posedge clock_iht) begin
        if (!reset_n) begin
            rr_interval  <= '0;
            rr_avg       <= '0;
            rr_irregular <= 1'b0;
            rr_valid     <= 1'b0;
            beat_count   <= '0;
            overflow     <= 1'b0;
        end else if (vld_p0) begin
            rr_interval  <= rr_p0;
            rr_avg       <= avg_p0;
            rr_irregular <= irr_p0;
            rr_valid     <= 1'b1;
            beat_count   <= sat_inc16(beat_count);
            if (rr_valid && !rr_ready) overflow <= 1'b1;
        end else if (rr_ready) begin
            rr_valid <= 1'b0;
        end
    end

endmodule
